// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Op codes arrive on a 3-bit field; codes 6 and 7 are no-ops.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_RUN,
        S_DIV_FIX
    } md_state_e;

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, DW cycles per divide.
// busy stays high while further iterations remain after the current one.
module div_radix2 #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          abort,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic [DW-1:0] quot,
    output logic [DW-1:0] rem
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvsr_q, dvsr_d;
    logic [DW:0]   shifted;
    logic [DW:0]   trial;

    assign shifted = {rem_q, quot_q[DW-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        if (load) begin
            active_d = 1'b1;
            cnt_d    = '0;
            quot_d   = dividend;
            rem_d    = '0;
            dvsr_d   = divisor;
        end else if (abort) begin
            active_d = 1'b0;
        end else if (active_q) begin
            // Restore when the trial subtraction borrows (MSB set).
            if (trial[DW]) begin
                rem_d  = shifted[DW-1:0];
                quot_d = {quot_q[DW-2:0], 1'b0};
            end else begin
                rem_d  = trial[DW-1:0];
                quot_d = {quot_q[DW-2:0], 1'b1};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DW-1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
        end
    end

    assign busy = active_q && (cnt_q != CW'(DW-1));
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// Multiplies and moves finish in one cycle; divides stall the pipeline for DW+1 cycles.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic          flush,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    md_state_e     state_q, state_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;

    logic            div_load, div_abort, div_busy;
    logic [DW-1:0]   div_quot, div_rem;
    logic            is_signed_div, a_neg, b_neg;
    logic [DW-1:0]   abs_a, abs_b;
    logic [2*DW-1:0] prod_s, prod_u;

    assign prod_s = $signed({{DW{src_a[DW-1]}}, src_a}) * $signed({{DW{src_b[DW-1]}}, src_b});
    assign prod_u = {{DW{1'b0}}, src_a} * {{DW{1'b0}}, src_b};

    assign is_signed_div = (op == MD_DIV);
    assign a_neg         = is_signed_div && src_a[DW-1];
    assign b_neg         = is_signed_div && src_b[DW-1];
    assign abs_a         = a_neg ? (~src_a + DW'(1)) : src_a;
    assign abs_b         = b_neg ? (~src_b + DW'(1)) : src_b;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div_load  = 1'b0;
        div_abort = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush && !rst) begin
                    case (op)
                        MD_MULT:  {hi_d, lo_d} = prod_s;
                        MD_MULTU: {hi_d, lo_d} = prod_u;
                        MD_MTHI:  hi_d = src_a;
                        MD_MTLO:  lo_d = src_a;
                        MD_DIV, MD_DIVU: begin
                            stall    = 1'b1;
                            div_load = 1'b1;
                            qneg_d   = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            state_d  = S_DIV_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_DIV_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    div_abort = 1'b1;
                    state_d   = S_IDLE;
                end else if (!div_busy) begin
                    state_d = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                // start is ignored here: it is the divide itself leaving EX.
                state_d = S_IDLE;
                if (!flush) begin
                    done = 1'b1;
                    lo_d = qneg_q ? (~div_quot + DW'(1)) : div_quot;
                    hi_d = rneg_q ? (~div_rem + DW'(1)) : div_rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    div_radix2 #(.DW(DW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .abort    (div_abort),
        .dividend (abs_a),
        .divisor  (abs_b),
        .busy     (div_busy),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: multiply, move, divide, flush and reset scenarios.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.DW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle op (MULT/MULTU/MTHI/MTLO); stall must stay low during accept.
    task automatic issue1(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
        step();
        start = 1'b0;
    endtask

    // Divide with start held until the done pulse; returns stall count and done cycle (0 = timeout).
    task automatic run_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int stall_cnt, output int done_cyc);
        stall_cnt = 0;
        done_cyc  = 0;
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (done) done_cyc = cyc;
            step();
            if (done_cyc != 0) break;
        end
        start = 1'b0;
    endtask

    int sc, dc;
    int seen_done;

    initial begin
        rst = 1'b1; start = 1'b1; op = MD_DIV; src_a = 32'd5; src_b = 32'd1; flush = 1'b0;

        // 1: reset with start asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_stall", {31'b0, stall}, 32'd0);
            check("rst_done",  {31'b0, done},  32'd0);
            check("rst_hi", hi, 32'd0);
            check("rst_lo", lo, 32'd0);
        end
        step();
        rst = 1'b0; start = 1'b0;

        // 2: MULT / MULTU
        issue1("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        step();
        issue1("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        step();

        // 3: DIV -7/2, start held through DIV_FIX
        run_div(MD_DIV, 32'hFFFF_FFF9, 32'd2, sc, dc);
        check("div_stall_cycles", sc, 32'd33);
        check("div_done_cycle", dc, 32'd34);
        @(negedge clk);
        check("div_no_restart", {31'b0, stall}, 32'd0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        step();

        // 4: divide by zero and INT_MIN / -1
        run_div(MD_DIVU, 32'h8000_0000, 32'd0, sc, dc);
        check("divz_done_cycle", dc, 32'd34);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h8000_0000);
        run_div(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc, dc);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        // 5: MTHI/MTLO, then flush a divide mid-run
        issue1("mthi", MD_MTHI, 32'h11, 32'hDEAD_BEEF);
        issue1("mtlo", MD_MTLO, 32'h22, 32'hDEAD_BEEF);
        @(negedge clk);
        check("mt_hi", hi, 32'h11);
        check("mt_lo", lo, 32'h22);
        step();
        start = 1'b1; op = MD_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_stall", {31'b0, stall}, 32'd1);
        step();
        flush = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || stall) seen_done = 1;
            if (i == 0) begin
                check("flush_stall", {31'b0, stall}, 32'd0);
                check("flush_hi", hi, 32'h11);
                check("flush_lo", lo, 32'h22);
            end
            step();
        end
        check("flush_no_done", seen_done, 32'd0);
        run_div(MD_DIVU, 32'd100, 32'd7, sc, dc);
        check("divu_done_cycle", dc, 32'd34);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // 6: flush at accept, then reset mid-divide
        start = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7; flush = 1'b1;
        @(negedge clk);
        check("accflush_stall0", {31'b0, stall}, 32'd0);
        step();
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("accflush_stall1", {31'b0, stall}, 32'd0);
        check("accflush_hi", hi, 32'd2);
        check("accflush_lo", lo, 32'd14);
        step();
        start = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
        step();
        start = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("pre_rst_stall", {31'b0, stall}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || stall) seen_done = 1;
        end
        check("midrst_idle", seen_done, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
